// File: rtl/ucontrol_sequencer.sv
// Microcoded control unit for the ARC-style 32-bit datapath: walks each instruction
// through fetch/decode/execute/PC-update and drives C-bus, A/B muxes, ALU, PSR and memory.
module ucontrol_sequencer #(
  parameter int DATAWIDTH_DECODER_SELECTION = 6,
  parameter int DATAWIDTH_MUX_SELECTION     = 6,
  parameter int DATAWIDTH_ALU_SELECTION     = 4,
  parameter int REG_PC    = 32,
  parameter int REG_TEMP0 = 33,
  parameter int REG_IR    = 37,
  parameter int REG_LINK  = 15
) (
  input  logic                                   uControl_CLOCK_50,
  input  logic                                   uControl_Reset_InHigh,
  input  logic [1:0]                             RegIR_OP,
  input  logic [2:0]                             RegIR_OP2,
  input  logic [5:0]                             RegIR_OP3,
  input  logic [4:0]                             RegIR_RD,
  input  logic [4:0]                             RegIR_RS1,
  input  logic                                   RegIR_BIT13,
  input  logic [4:0]                             RegIR_RS2,
  input  logic                                   PSR_Negative_InHigh,
  input  logic                                   PSR_Zero_InHigh,
  input  logic                                   PSR_Overflow_InHigh,
  input  logic                                   PSR_Carry_InHigh,
  input  logic                                   uControl_MemReady_InHigh,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uControl_DecoderSel_Out,
  output logic                                   uControl_DecoderWrite_Out,
  output logic                                   uControl_CSrcMem_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     uControl_MuxA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     uControl_MuxB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     uControl_ALUSel_Out,
  output logic                                   uControl_PSRLoad_Out,
  output logic                                   uControl_MemRead_Out,
  output logic                                   uControl_MemWrite_Out,
  output logic                                   uControl_Illegal_Out,
  output logic [3:0]                             uControl_State_Out
);
  localparam int DW = DATAWIDTH_DECODER_SELECTION;
  localparam int MW = DATAWIDTH_MUX_SELECTION;
  localparam int AW = DATAWIDTH_ALU_SELECTION;

  localparam logic [DW-1:0] SEL_PC = DW'(REG_PC),  SEL_T0 = DW'(REG_TEMP0);
  localparam logic [DW-1:0] SEL_IR = DW'(REG_IR),  SEL_LK = DW'(REG_LINK);
  localparam logic [MW-1:0] MUX_PC = MW'(REG_PC),  MUX_T0 = MW'(REG_TEMP0);
  localparam logic [MW-1:0] MUX_IR = MW'(REG_IR);

  localparam logic [AW-1:0] ALU_ANDCC = AW'(0),  ALU_ORCC  = AW'(1),  ALU_ORNCC = AW'(2);
  localparam logic [AW-1:0] ALU_ADDCC = AW'(3),  ALU_SRL   = AW'(4),  ALU_ADD   = AW'(9);
  localparam logic [AW-1:0] ALU_INCPC = AW'(10), ALU_SETHI = AW'(11), ALU_SIMM  = AW'(12);
  localparam logic [AW-1:0] ALU_D22   = AW'(13), ALU_D30   = AW'(14), ALU_PASSA = AW'(15);

  // Branch and call PC+temp0 share one state so the whole machine fits the 4-bit debug port.
  typedef enum logic [3:0] {
    S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_IMM    = 4'd3,
    S_ALU   = 4'd4,  S_ADDR  = 4'd5,  S_LDMEM  = 4'd6, S_STMEM  = 4'd7,
    S_SETHI = 4'd8,  S_BRTST = 4'd9,  S_BR1    = 4'd10, S_PCADD = 4'd11,
    S_CALL1 = 4'd12, S_CALL2 = 4'd13, S_PCINC  = 4'd14, S_ILL   = 4'd15
  } state_t;

  state_t r_state, w_next;

  logic w_alu_op, w_mem_op, w_rd_nz, w_taken, w_cc;
  logic [AW-1:0] w_alu_fn;

  always_comb begin
    w_rd_nz  = (RegIR_RD != 5'd0);
    w_alu_op = (RegIR_OP == 2'b10) &&
               (RegIR_OP3 inside {6'b000000, 6'b010000, 6'b010001,
                                  6'b010010, 6'b010110, 6'b100110});
    w_mem_op = (RegIR_OP == 2'b11) && (RegIR_OP3 inside {6'b000000, 6'b000100});
    w_cc     = 1'b0;
    w_alu_fn = ALU_ADD;
    case (RegIR_OP3)
      6'b010000: begin w_alu_fn = ALU_ADDCC; w_cc = 1'b1; end
      6'b010001: begin w_alu_fn = ALU_ANDCC; w_cc = 1'b1; end
      6'b010010: begin w_alu_fn = ALU_ORCC;  w_cc = 1'b1; end
      6'b010110: begin w_alu_fn = ALU_ORNCC; w_cc = 1'b1; end
      6'b100110: w_alu_fn = ALU_SRL;
      default:   w_alu_fn = ALU_ADD;
    endcase
    case (RegIR_RD[3:0])
      4'b1000: w_taken = 1'b1;
      4'b0001: w_taken = PSR_Zero_InHigh;
      4'b0101: w_taken = PSR_Carry_InHigh;
      4'b0110: w_taken = PSR_Negative_InHigh;
      4'b0111: w_taken = PSR_Overflow_InHigh;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge uControl_CLOCK_50) begin
    if (uControl_Reset_InHigh) r_state <= S_RESET;
    else                       r_state <= w_next;
  end

  always_comb begin
    w_next                    = r_state;
    uControl_DecoderSel_Out   = '0;
    uControl_DecoderWrite_Out = 1'b0;
    uControl_CSrcMem_Out      = 1'b0;
    uControl_MuxA_Out         = '0;
    uControl_MuxB_Out         = '0;
    uControl_ALUSel_Out       = '0;
    uControl_PSRLoad_Out      = 1'b0;
    uControl_MemRead_Out      = 1'b0;
    uControl_MemWrite_Out     = 1'b0;
    uControl_Illegal_Out      = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        uControl_MuxA_Out         = MUX_PC;
        uControl_MemRead_Out      = 1'b1;
        uControl_DecoderSel_Out   = SEL_IR;
        uControl_CSrcMem_Out      = 1'b1;
        uControl_DecoderWrite_Out = uControl_MemReady_InHigh;
        if (uControl_MemReady_InHigh) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_alu_op)                                     w_next = RegIR_BIT13 ? S_IMM : S_ALU;
        else if (w_mem_op)                                w_next = RegIR_BIT13 ? S_IMM : S_ADDR;
        else if (RegIR_OP == 2'b00 && RegIR_OP2 == 3'b100) w_next = S_SETHI;
        else if (RegIR_OP == 2'b00 && RegIR_OP2 == 3'b010) w_next = S_BRTST;
        else if (RegIR_OP == 2'b01)                       w_next = S_CALL1;
        else                                              w_next = S_ILL;
      end
      S_IMM: begin
        uControl_MuxB_Out         = MUX_IR;
        uControl_ALUSel_Out       = ALU_SIMM;
        uControl_DecoderSel_Out   = SEL_T0;
        uControl_DecoderWrite_Out = 1'b1;
        w_next = (RegIR_OP == 2'b11) ? S_ADDR : S_ALU;
      end
      S_ALU: begin
        uControl_MuxA_Out         = MW'(RegIR_RS1);
        uControl_MuxB_Out         = RegIR_BIT13 ? MUX_T0 : MW'(RegIR_RS2);
        uControl_ALUSel_Out       = w_alu_fn;
        uControl_DecoderSel_Out   = DW'(RegIR_RD);
        uControl_DecoderWrite_Out = w_rd_nz;
        uControl_PSRLoad_Out      = w_cc;
        w_next = S_PCINC;
      end
      S_ADDR: begin
        uControl_MuxA_Out         = MW'(RegIR_RS1);
        uControl_MuxB_Out         = RegIR_BIT13 ? MUX_T0 : MW'(RegIR_RS2);
        uControl_ALUSel_Out       = ALU_ADD;
        uControl_DecoderSel_Out   = SEL_T0;
        uControl_DecoderWrite_Out = 1'b1;
        w_next = (RegIR_OP3 == 6'b000000) ? S_LDMEM : S_STMEM;
      end
      S_LDMEM: begin
        uControl_MuxA_Out         = MUX_T0;
        uControl_MemRead_Out      = 1'b1;
        uControl_CSrcMem_Out      = 1'b1;
        uControl_DecoderSel_Out   = DW'(RegIR_RD);
        uControl_DecoderWrite_Out = uControl_MemReady_InHigh & w_rd_nz;
        if (uControl_MemReady_InHigh) w_next = S_PCINC;
      end
      S_STMEM: begin
        uControl_MuxA_Out     = MUX_T0;
        uControl_MuxB_Out     = MW'(RegIR_RD);
        uControl_MemWrite_Out = 1'b1;
        if (uControl_MemReady_InHigh) w_next = S_PCINC;
      end
      S_SETHI: begin
        uControl_MuxB_Out         = MUX_IR;
        uControl_ALUSel_Out       = ALU_SETHI;
        uControl_DecoderSel_Out   = DW'(RegIR_RD);
        uControl_DecoderWrite_Out = w_rd_nz;
        w_next = S_PCINC;
      end
      S_BRTST: w_next = w_taken ? S_BR1 : S_PCINC;
      S_BR1: begin
        uControl_MuxB_Out         = MUX_IR;
        uControl_ALUSel_Out       = ALU_D22;
        uControl_DecoderSel_Out   = SEL_T0;
        uControl_DecoderWrite_Out = 1'b1;
        w_next = S_PCADD;
      end
      S_PCADD: begin
        uControl_MuxA_Out         = MUX_PC;
        uControl_MuxB_Out         = MUX_T0;
        uControl_ALUSel_Out       = ALU_ADD;
        uControl_DecoderSel_Out   = SEL_PC;
        uControl_DecoderWrite_Out = 1'b1;
        w_next = S_FETCH;
      end
      S_CALL1: begin
        uControl_MuxA_Out         = MUX_PC;
        uControl_ALUSel_Out       = ALU_PASSA;
        uControl_DecoderSel_Out   = SEL_LK;
        uControl_DecoderWrite_Out = 1'b1;
        w_next = S_CALL2;
      end
      S_CALL2: begin
        uControl_MuxB_Out         = MUX_IR;
        uControl_ALUSel_Out       = ALU_D30;
        uControl_DecoderSel_Out   = SEL_T0;
        uControl_DecoderWrite_Out = 1'b1;
        w_next = S_PCADD;
      end
      S_PCINC: begin
        uControl_MuxA_Out         = MUX_PC;
        uControl_ALUSel_Out       = ALU_INCPC;
        uControl_DecoderSel_Out   = SEL_PC;
        uControl_DecoderWrite_Out = 1'b1;
        w_next = S_FETCH;
      end
      S_ILL: uControl_Illegal_Out = 1'b1;
      default: w_next = S_RESET;
    endcase
  end

  assign uControl_State_Out = r_state;
endmodule
